// File: rtl/menu_processor.sv
// Full-screen menu processor: copies the frame image to the display region on every vsync,
// blanking blink-class text and highlighting the selected item; keys move or commit the selection.
module menu_processor #(
  parameter logic [15:0] FRAME_BASE   = 16'h0800,
  parameter int unsigned FRAME_WORDS  = 1280,
  parameter logic [15:0] REGION_MASK  = 16'hA800,
  parameter int unsigned ROW_WORDS    = 40,
  parameter int unsigned ITEMS        = 4,
  parameter int unsigned ITEM_ROW0    = 12,
  parameter int unsigned ITEM_PITCH   = 2,
  parameter int unsigned BLINK_PERIOD = 25,
  parameter logic [2:0]  HILITE_ATTR  = 3'b011,
  parameter logic [7:0]  KEY_UP       = 8'h75,
  parameter logic [7:0]  KEY_DOWN     = 8'h72,
  parameter logic [7:0]  KEY_SELECT   = 8'h20,
  localparam int unsigned IW          = (ITEMS > 1) ? $clog2(ITEMS) : 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          ENABLE,
  output logic          SWITCH_REQUEST,
  output logic [IW-1:0] SWITCH_SEL,
  output logic          FATAL_ERROR,
  output logic          MEM_ENABLE,
  output logic          MEM_WRITE,
  output logic [15:0]   MEM_ADDR,
  input  logic [15:0]   MEM_DATA_R,
  output logic [15:0]   MEM_DATA_W,
  input  logic          GPU_READY,
  output logic          GPU_REQUEST,
  output logic          GPU_DRAW,
  input  logic [7:0]    KBD_KEY,
  input  logic [1:0]    INT_IRQ,
  output logic          INT_IACK,
  output logic          INT_IEND
);

  localparam int unsigned ColW = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
  localparam int unsigned FcW  = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

  localparam logic [15:0]   LastSrc    = FRAME_BASE + 16'(FRAME_WORDS - 1);
  localparam logic [ColW-1:0] ColLast  = ColW'(ROW_WORDS - 1);
  localparam logic [FcW-1:0]  FcLast   = FcW'(BLINK_PERIOD - 1);
  localparam logic [IW-1:0]   SelLast  = IW'(ITEMS - 1);
  localparam logic [15:0]   SelRowFirst = 16'(ITEM_ROW0);
  localparam logic [15:0]   SelRowLast  = 16'(ITEM_ROW0 + (ITEMS - 1) * ITEM_PITCH);
  localparam logic [15:0]   Pitch       = 16'(ITEM_PITCH);

  // Five-bit encoding leaves spare codes so a corrupted state lands in StError.
  typedef enum logic [4:0] {
    StInit, StArm, StIdle, StVack, StGreq, StRd, StLd, StXf, StWr, StNx,
    StDraw, StVend, StKack, StKend, StSwitch, StError
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     addr_q, addr_d;
  logic [15:0]     buf_q, buf_d;
  logic [15:0]     row_q, row_d;
  logic [ColW-1:0] col_q, col_d;
  logic [IW-1:0]   sel_q, sel_d;
  logic [15:0]     sel_row_q, sel_row_d;
  logic [FcW-1:0]  fc_q, fc_d;
  logic            visible_q, visible_d;
  logic [7:0]      key_q, key_d;
  logic [IW-1:0]   switch_sel_q, switch_sel_d;

  logic            mem_enable_d, mem_write_d, gpu_request_d, gpu_draw_d;
  logic            iack_d, iend_d, switch_request_d, fatal_d;
  logic [15:0]     mem_addr_d, mem_data_w_d;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    buf_d        = buf_q;
    row_d        = row_q;
    col_d        = col_q;
    sel_d        = sel_q;
    sel_row_d    = sel_row_q;
    fc_d         = fc_q;
    visible_d    = visible_q;
    key_d        = key_q;
    switch_sel_d = switch_sel_q;

    unique case (state_q)
      StInit, StArm: begin
        // Rewind the copy pointers here so every frame starts at the first source word.
        addr_d  = FRAME_BASE;
        row_d   = '0;
        col_d   = '0;
        state_d = (state_q == StInit) ? StArm : StIdle;
      end
      StIdle: begin
        if (INT_IRQ == 2'd0) begin
          state_d = StVack;
        end else if (INT_IRQ == 2'd1) begin
          state_d = StKack;
        end
      end
      StVack: begin
        if (fc_q == '0) visible_d = ~visible_q;
        fc_d    = (fc_q == FcLast) ? '0 : fc_q + FcW'(1);
        state_d = StGreq;
      end
      StGreq: if (GPU_READY) state_d = StRd;
      StRd:   state_d = StLd;
      StLd: begin
        buf_d   = MEM_DATA_R;
        addr_d  = addr_q ^ REGION_MASK;
        state_d = StXf;
      end
      StXf: begin
        if (buf_q[10:8] == 3'b001 && !visible_q) begin
          buf_d = '0;
        end else if (buf_q[10:8] == 3'b010 && row_q == sel_row_q) begin
          buf_d[10:8] = HILITE_ATTR;
        end
        state_d = StWr;
      end
      StWr:   state_d = StNx;
      StNx: begin
        addr_d = (addr_q ^ REGION_MASK) + 16'd1;
        if (col_q == ColLast) begin
          col_d = '0;
          row_d = row_q + 16'd1;
        end else begin
          col_d = col_q + ColW'(1);
        end
        state_d = ((addr_q ^ REGION_MASK) == LastSrc) ? StDraw : StRd;
      end
      StDraw: state_d = StVend;
      StVend: state_d = StArm;
      StKack: begin
        key_d   = KBD_KEY;
        state_d = StKend;
      end
      StKend: begin
        state_d = StArm;
        if (key_q == KEY_UP) begin
          sel_d     = (sel_q == '0) ? SelLast : sel_q - IW'(1);
          sel_row_d = (sel_q == '0) ? SelRowLast : sel_row_q - Pitch;
        end else if (key_q == KEY_DOWN) begin
          sel_d     = (sel_q == SelLast) ? '0 : sel_q + IW'(1);
          sel_row_d = (sel_q == SelLast) ? SelRowFirst : sel_row_q + Pitch;
        end else if (key_q == KEY_SELECT) begin
          switch_sel_d = sel_q;
          state_d      = StSwitch;
        end
      end
      StSwitch: state_d = StSwitch;
      StError:  state_d = StError;
      default:  state_d = StError;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    mem_enable_d     = (state_d == StRd) || (state_d == StWr);
    mem_write_d      = (state_d == StWr);
    mem_addr_d       = mem_enable_d ? addr_d : 16'h0000;
    mem_data_w_d     = mem_write_d ? buf_d : 16'h0000;
    gpu_request_d    = (state_d == StGreq);
    gpu_draw_d       = (state_d == StDraw);
    iack_d           = (state_d == StVack) || (state_d == StKack);
    iend_d           = (state_d == StVend) || (state_d == StKend);
    switch_request_d = (state_d == StSwitch);
    fatal_d          = (state_d == StError);
  end

  always_ff @(posedge CLK) begin
    if (RESET || !ENABLE) begin
      state_q        <= StInit;
      addr_q         <= FRAME_BASE;
      buf_q          <= '0;
      row_q          <= '0;
      col_q          <= '0;
      sel_q          <= '0;
      sel_row_q      <= SelRowFirst;
      fc_q           <= '0;
      visible_q      <= 1'b0;
      key_q          <= '0;
      switch_sel_q   <= '0;
      MEM_ENABLE     <= 1'b0;
      MEM_WRITE      <= 1'b0;
      MEM_ADDR       <= '0;
      MEM_DATA_W     <= '0;
      GPU_REQUEST    <= 1'b0;
      GPU_DRAW       <= 1'b0;
      INT_IACK       <= 1'b0;
      INT_IEND       <= 1'b0;
      SWITCH_REQUEST <= 1'b0;
      FATAL_ERROR    <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      buf_q          <= buf_d;
      row_q          <= row_d;
      col_q          <= col_d;
      sel_q          <= sel_d;
      sel_row_q      <= sel_row_d;
      fc_q           <= fc_d;
      visible_q      <= visible_d;
      key_q          <= key_d;
      switch_sel_q   <= switch_sel_d;
      MEM_ENABLE     <= mem_enable_d;
      MEM_WRITE      <= mem_write_d;
      MEM_ADDR       <= mem_addr_d;
      MEM_DATA_W     <= mem_data_w_d;
      GPU_REQUEST    <= gpu_request_d;
      GPU_DRAW       <= gpu_draw_d;
      INT_IACK       <= iack_d;
      INT_IEND       <= iend_d;
      SWITCH_REQUEST <= switch_request_d;
      FATAL_ERROR    <= fatal_d;
    end
  end

  assign SWITCH_SEL = switch_sel_q;

endmodule

// File: tb/tb_menu_processor.sv
// Directed bench for menu_processor: a scoreboard of expected display writes is filled at each
// vsync acknowledge and drained as the DUT writes; a reduced frame keeps the blink run short.
module tb_menu_processor;

  localparam int unsigned FrameWords  = 80;
  localparam int unsigned RowWords    = 4;
  localparam int unsigned BlinkPeriod = 25;
  localparam int unsigned Items       = 4;
  localparam int unsigned Budget      = 2000;
  localparam logic [15:0] SrcBase     = 16'h0800;
  localparam logic [15:0] DispBase    = 16'hA000;
  localparam logic [7:0]  KeyUp       = 8'h75;
  localparam logic [7:0]  KeyDown     = 8'h72;
  localparam logic [7:0]  KeySelect   = 8'h20;

  logic        CLK = 1'b0;
  logic        RESET, ENABLE, GPU_READY;
  logic [7:0]  KBD_KEY;
  logic [1:0]  INT_IRQ;
  logic [15:0] MEM_DATA_R;
  logic        SWITCH_REQUEST, FATAL_ERROR, MEM_ENABLE, MEM_WRITE;
  logic        GPU_REQUEST, GPU_DRAW, INT_IACK, INT_IEND;
  logic [1:0]  SWITCH_SEL;
  logic [15:0] MEM_ADDR, MEM_DATA_W;

  always #5 CLK = ~CLK;

  menu_processor #(
    .FRAME_WORDS (FrameWords),
    .ROW_WORDS   (RowWords)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .ENABLE         (ENABLE),
    .SWITCH_REQUEST (SWITCH_REQUEST),
    .SWITCH_SEL     (SWITCH_SEL),
    .FATAL_ERROR    (FATAL_ERROR),
    .MEM_ENABLE     (MEM_ENABLE),
    .MEM_WRITE      (MEM_WRITE),
    .MEM_ADDR       (MEM_ADDR),
    .MEM_DATA_R     (MEM_DATA_R),
    .MEM_DATA_W     (MEM_DATA_W),
    .GPU_READY      (GPU_READY),
    .GPU_REQUEST    (GPU_REQUEST),
    .GPU_DRAW       (GPU_DRAW),
    .KBD_KEY        (KBD_KEY),
    .INT_IRQ        (INT_IRQ),
    .INT_IACK       (INT_IACK),
    .INT_IEND       (INT_IEND)
  );

  typedef struct {
    int unsigned cyc;
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  logic [15:0] src_mem [65536];
  wr_t         act_q[$];
  wr_t         exp_q[$];
  logic [15:0] rd_log[$];
  int unsigned cyc = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  int          n_vs = 0;
  int          sel_m = 0;

  // Memory model: read data valid the cycle after the read request.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (MEM_ENABLE && !MEM_WRITE) begin
      MEM_DATA_R <= src_mem[MEM_ADDR];
      rd_log.push_back(MEM_ADDR);
    end
    if (MEM_ENABLE && MEM_WRITE) act_q.push_back('{cyc, MEM_ADDR, MEM_DATA_W});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_word(input logic [15:0] src, input int row,
                                             input int sel, input bit vis);
    if (src[10:8] == 3'b001 && !vis) return 16'h0000;
    if (src[10:8] == 3'b010 && row == 12 + 2 * sel) return {src[15:11], 3'b011, src[7:0]};
    return src;
  endfunction

  task automatic check_quiet_outputs(input string tag);
    check({tag, " ctl"}, {SWITCH_REQUEST, FATAL_ERROR, MEM_ENABLE, MEM_WRITE, GPU_REQUEST,
                          GPU_DRAW, INT_IACK, INT_IEND}, 8'h00);
    check({tag, " addr"}, MEM_ADDR, 16'h0000);
    check({tag, " wdata"}, MEM_DATA_W, 16'h0000);
    check({tag, " swsel"}, SWITCH_SEL, 2'd0);
  endtask

  task automatic wait_iack(input string tag, output int lat);
    lat = 0;
    while (INT_IACK !== 1'b1 && lat < Budget) begin
      @(negedge CLK);
      lat++;
    end
    check({tag, " iack"}, INT_IACK, 1'b1);
  endtask

  task automatic wait_iend(input string tag);
    int k = 0;
    while (INT_IEND !== 1'b1 && k < Budget) begin
      @(negedge CLK);
      k++;
    end
    check({tag, " iend"}, INT_IEND, 1'b1);
  endtask

  task automatic push_frame();
    wr_t e;
    bit  vis = (((n_vs - 1) / BlinkPeriod) % 2) == 0;
    for (int i = 0; i < int'(FrameWords); i++) begin
      e.cyc  = 0;
      e.addr = DispBase + 16'(i);
      e.data = model_word(src_mem[SrcBase + 16'(i)], i / RowWords, sel_m, vis);
      exp_q.push_back(e);
    end
  endtask

  task automatic start_vsync(input string tag, output int lat);
    INT_IRQ = 2'd0;
    wait_iack(tag, lat);
    INT_IRQ = 2'd2;
    n_vs++;
    push_frame();
  endtask

  // Drains writes against the scoreboard until INT_IEND, then checks the DRAW/IEND tail.
  task automatic finish_vsync(input string tag);
    int          k = 0;
    int          idx = 0;
    int          draw_n = 0;
    int unsigned draw_c = 0;
    int unsigned prev = 0;
    wr_t         a, e;
    while (INT_IEND !== 1'b1 && k < Budget) begin
      @(negedge CLK);
      k++;
      if (GPU_DRAW) begin
        draw_n++;
        draw_c = cyc;
      end
      while (act_q.size() > 0) begin
        a = act_q.pop_front();
        idx++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check({tag, " waddr"}, a.addr, e.addr);
          check({tag, " wdata"}, a.data, e.data);
          if (idx > 1) check({tag, " wspacing"}, a.cyc - prev, 5);
        end
        prev = a.cyc;
      end
    end
    check({tag, " iend"}, INT_IEND, 1'b1);
    check({tag, " write count"}, idx, FrameWords);
    check({tag, " draw pulses"}, draw_n, 1);
    check({tag, " draw before iend"}, draw_c, cyc - 1);
    exp_q.delete();
    @(negedge CLK);
    check({tag, " iend one cycle"}, INT_IEND, 1'b0);
  endtask

  task automatic vsync(input string tag);
    int lat;
    start_vsync(tag, lat);
    finish_vsync(tag);
  endtask

  task automatic keypress(input string tag, input logic [7:0] key);
    int lat;
    KBD_KEY = key;
    INT_IRQ = 2'd1;
    wait_iack(tag, lat);
    INT_IRQ = 2'd2;
    wait_iend(tag);
    if (key == KeyUp) sel_m = (sel_m == 0) ? Items - 1 : sel_m - 1;
    else if (key == KeyDown) sel_m = (sel_m == Items - 1) ? 0 : sel_m + 1;
  endtask

  initial begin
    int lat;
    int bad_req, bad_mem, bad_iack, bad_sw;
    int k;

    for (int i = 0; i < 65536; i++) src_mem[i] = 16'h0000;
    for (int i = 0; i < int'(FrameWords); i++) src_mem[SrcBase + 16'(i)] = 16'h5000 + 16'(i);
    src_mem[SrcBase]          = 16'h0141;
    src_mem[SrcBase + 16'd6]  = 16'h0250;
    for (int j = 0; j < int'(Items); j++) src_mem[SrcBase + 16'((12 + 2 * j) * RowWords + 1)] = 16'h0241;

    RESET = 1'b1; ENABLE = 1'b1; GPU_READY = 1'b1; KBD_KEY = 8'h00; INT_IRQ = 2'd2;
    repeat (3) @(negedge CLK);
    check_quiet_outputs("reset");
    RESET = 1'b0;
    repeat (4) @(negedge CLK);
    check_quiet_outputs("post reset idle");

    // First frame: visible becomes 1, item 0 highlighted.
    vsync("vsync1");

    // Foreign interrupts are ignored and leave the FSM idling.
    bad_iack = 0; bad_mem = 0;
    INT_IRQ = 2'd3;
    repeat (20) begin
      @(negedge CLK);
      if (INT_IACK) bad_iack++;
      if (MEM_ENABLE) bad_mem++;
    end
    INT_IRQ = 2'd2;
    repeat (20) begin
      @(negedge CLK);
      if (INT_IACK) bad_iack++;
      if (MEM_ENABLE) bad_mem++;
    end
    check("foreign irq iack", bad_iack, 0);
    check("foreign irq mem", bad_mem, 0);
    start_vsync("vsync2", lat);
    check("idle vsync latency", lat, 1);
    finish_vsync("vsync2");

    // GPU stall: request held, no memory traffic.
    GPU_READY = 1'b0;
    start_vsync("vsync3", lat);
    bad_req = 0; bad_mem = 0;
    repeat (100) begin
      @(negedge CLK);
      if (GPU_REQUEST !== 1'b1) bad_req++;
      if (MEM_ENABLE !== 1'b0) bad_mem++;
    end
    check("stall gpu request", bad_req, 0);
    check("stall mem idle", bad_mem, 0);
    GPU_READY = 1'b1;
    finish_vsync("vsync3");

    for (int v = 4; v <= 52; v++) vsync("blink");

    for (int p = 0; p < 4; p++) begin
      keypress("key down", KeyDown);
      vsync("hilite down");
    end
    keypress("key other", 8'h41);
    vsync("hilite other");
    keypress("key up", KeyUp);
    vsync("hilite up wrap");

    // Reset part-way through a frame.
    INT_IRQ = 2'd0;
    wait_iack("midreset", lat);
    INT_IRQ = 2'd2;
    k = 0;
    while (act_q.size() < 40 && k < Budget) begin
      @(negedge CLK);
      k++;
    end
    check("midreset reached word 40", act_q.size() >= 40, 1'b1);
    RESET = 1'b1;
    @(negedge CLK);
    check_quiet_outputs("midreset");
    RESET = 1'b0;
    act_q.delete();
    rd_log.delete();
    n_vs = 0;
    sel_m = 0;
    repeat (3) @(negedge CLK);
    vsync("after midreset");
    check("restart source addr", (rd_log.size() > 0) ? 32'(rd_log[0]) : 32'hFFFF_FFFF, SrcBase);

    // Commit item 2, then hold until ENABLE drops.
    keypress("sel down a", KeyDown);
    keypress("sel down b", KeyDown);
    keypress("select", KeySelect);
    @(negedge CLK);
    check("switch request", SWITCH_REQUEST, 1'b1);
    check("switch sel", SWITCH_SEL, 2'd2);
    bad_sw = 0; bad_iack = 0; bad_mem = 0;
    INT_IRQ = 2'd0;
    repeat (30) begin
      @(negedge CLK);
      if (SWITCH_REQUEST !== 1'b1 || SWITCH_SEL !== 2'd2) bad_sw++;
      if (INT_IACK) bad_iack++;
      if (MEM_ENABLE) bad_mem++;
    end
    INT_IRQ = 2'd1;
    repeat (10) begin
      @(negedge CLK);
      if (INT_IACK) bad_iack++;
    end
    INT_IRQ = 2'd2;
    check("switch held", bad_sw, 0);
    check("switch no iack", bad_iack, 0);
    check("switch no mem", bad_mem, 0);
    ENABLE = 1'b0;
    @(negedge CLK);
    check_quiet_outputs("disable");
    ENABLE = 1'b1;
    n_vs = 0;
    sel_m = 0;
    repeat (3) @(negedge CLK);
    vsync("after disable");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
